// File: rtl/input_unit_split_arbiter.sv
// ---------------------------------------------------------------------------
// input_unit_split_arbiter
//
// Purpose: arbitrates the SPLIT buffers of one router input unit towards two
// independent consumers:
//   * RC arbiter:   combinational round-robin over rc_req_split. The grant is
//                   gated by rc_ready. The pointer advances past the winner.
//   * SA controller: IDLE/REQ/LOCK FSM. It picks one split (sa_win) and holds
//                   it for a whole packet (wormhole) until the tail flit is
//                   acknowledged.
//
// Handshakes: a request bit is a level that the split holds while it waits.
// rc_req/rc_ready: a transfer happens in any cycle where rc_grant_split is
// nonzero. sa_req/sa_ack: a flit moves only in a cycle where sa_grant_split
// is nonzero and sa_ack=1. An sa_ack seen while sa_grant_split is zero moves
// nothing and is ignored.
//
// Optional feature: define SPLIT_ARB_WDOG_EN to build in the REQ-state
// watchdog and the sa_timeout port.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rc_req_split    per-split RC request        rc_ready     RC can accept
//   rc_grant_split  one-hot/zero RC grant
//   sa_req_split    per-split SA request        sa_tail_split head is tail
//   sa_ack          allocator accepted flit     sa_grant_split one-hot/zero
//   sa_locked       FSM in LOCK (packet in flight)
//   sa_timeout      1-cycle watchdog pulse (SPLIT_ARB_WDOG_EN only)
//   dbg_state_o     SA FSM state: 0=IDLE, 1=REQ, 2=LOCK
//   dbg_rc_ptr_o    RC round-robin pointer
//   dbg_sa_ptr_o    SA round-robin pointer
//
// SPLIT must be at least 2.
// ---------------------------------------------------------------------------
module input_unit_split_arbiter #(
    parameter int SPLIT      = 4,
    parameter int WDOG_LIMIT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SPLIT-1:0]         rc_req_split,
    input  logic                     rc_ready,
    output logic [SPLIT-1:0]         rc_grant_split,
    input  logic [SPLIT-1:0]         sa_req_split,
    input  logic [SPLIT-1:0]         sa_tail_split,
    input  logic                     sa_ack,
    output logic [SPLIT-1:0]         sa_grant_split,
    output logic                     sa_locked,
`ifdef SPLIT_ARB_WDOG_EN
    output logic                     sa_timeout,
`endif
    output logic [1:0]               dbg_state_o,
    output logic [$clog2(SPLIT)-1:0] dbg_rc_ptr_o,
    output logic [$clog2(SPLIT)-1:0] dbg_sa_ptr_o
);
    localparam int PW = $clog2(SPLIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_LOCK = 2'd2
    } sa_state_e;

    typedef logic [PW-1:0] ptr_t;

    // (p + 1) mod SPLIT; also correct when SPLIT is not a power of two.
    function automatic ptr_t ptr_inc(input ptr_t p);
        if (int'(p) == SPLIT - 1) return '0;
        return p + ptr_t'(1);
    endfunction

    // Round-robin pick: the first requester at or after ptr, wrapping.
    // The scan runs from the farthest offset down to the nearest. The nearest
    // requester is found last and overwrites any farther one.
    function automatic logic [SPLIT-1:0] rr_onehot(input logic [SPLIT-1:0] req,
                                                   input ptr_t ptr);
        logic [SPLIT-1:0] g;
        int               k;
        ptr_t             kk;
        g = '0;
        for (int i = SPLIT - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= SPLIT) k = k - SPLIT;
            kk = ptr_t'(k);
            if (req[kk]) begin
                g     = '0;
                g[kk] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic ptr_t oh2idx(input logic [SPLIT-1:0] oh);
        ptr_t r;
        r = '0;
        for (int i = 0; i < SPLIT; i++) begin
            if (oh[i]) r = r | ptr_t'(i);
        end
        return r;
    endfunction

    sa_state_e        state_q;
    logic [SPLIT-1:0] sa_win_q;
    ptr_t             sa_ptr_q;
    ptr_t             rc_ptr_q, rc_ptr_d;
    logic [SPLIT-1:0] rc_pick;
    logic             sa_ack_eff;
    logic             win_tail;
    logic             win_req;
    ptr_t             win_next;
`ifdef SPLIT_ARB_WDOG_EN
    logic [3:0]       wdog_q;
    logic             timeout_q;
`endif

    // RC arbiter: zero latency. The pointer moves only when a grant goes out.
    always_comb begin
        rc_pick        = rr_onehot(rc_req_split, rc_ptr_q);
        rc_grant_split = rc_ready ? rc_pick : '0;
        rc_ptr_d       = rc_ptr_q;
        if (|rc_grant_split) rc_ptr_d = ptr_inc(oh2idx(rc_grant_split));
    end

    // The winner keeps its grant only while it still requests. This also
    // makes sa_ack without a visible grant a no-op.
    assign sa_grant_split = (state_q != S_IDLE) ? (sa_win_q & sa_req_split) : '0;
    assign sa_ack_eff     = sa_ack & (|sa_grant_split);
    assign win_tail       = |(sa_win_q & sa_tail_split);
    assign win_req        = |(sa_win_q & sa_req_split);
    assign win_next       = ptr_inc(oh2idx(sa_win_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sa_win_q  <= '0;
            sa_ptr_q  <= '0;
            rc_ptr_q  <= '0;
`ifdef SPLIT_ARB_WDOG_EN
            wdog_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            rc_ptr_q <= rc_ptr_d;
`ifdef SPLIT_ARB_WDOG_EN
            timeout_q <= 1'b0;
            wdog_q    <= '0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (|sa_req_split) begin
                        state_q  <= S_REQ;
                        sa_win_q <= rr_onehot(sa_req_split, sa_ptr_q);
                    end
                end
                S_REQ: begin
                    if (sa_ack_eff) begin
                        if (win_tail) begin
                            state_q  <= S_IDLE;
                            sa_ptr_q <= win_next;
                        end else begin
                            state_q  <= S_LOCK;
                        end
                    end else if (!win_req) begin
                        // Winner withdrew before any flit moved; its turn is not consumed.
                        state_q <= S_IDLE;
                    end
`ifdef SPLIT_ARB_WDOG_EN
                    else if (wdog_q == 4'(WDOG_LIMIT - 1)) begin
                        // This is the WDOG_LIMIT-th stalled REQ cycle: give the turn away.
                        state_q   <= S_IDLE;
                        sa_ptr_q  <= win_next;
                        timeout_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 4'd1;
                    end
`endif
                end
                S_LOCK: begin
                    // Wormhole hold: only the acknowledged tail releases the grant.
                    if (sa_ack_eff && win_tail) begin
                        state_q  <= S_IDLE;
                        sa_ptr_q <= win_next;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sa_locked    = (state_q == S_LOCK);
    assign dbg_state_o  = state_q;
    assign dbg_rc_ptr_o = rc_ptr_q;
    assign dbg_sa_ptr_o = sa_ptr_q;
`ifdef SPLIT_ARB_WDOG_EN
    assign sa_timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_input_unit_split_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for input_unit_split_arbiter. Inputs change on the falling edge and
// outputs are checked 1 ns later. A behavioural model advances on each
// rising edge. The model tracks the packet owner, the round-robin pointers
// and the watchdog stall count.
// ---------------------------------------------------------------------------
module tb_input_unit_split_arbiter;
  localparam int SPLIT      = 4;
  localparam int WDOG_LIMIT = 15;

  logic             clk;
  logic             rst;
  logic [SPLIT-1:0] rc_req_split;
  logic             rc_ready;
  logic [SPLIT-1:0] rc_grant_split;
  logic [SPLIT-1:0] sa_req_split;
  logic [SPLIT-1:0] sa_tail_split;
  logic             sa_ack;
  logic [SPLIT-1:0] sa_grant_split;
  logic             sa_locked;
`ifdef SPLIT_ARB_WDOG_EN
  logic             sa_timeout;
`endif
  logic [1:0]       dbg_state_o;
  logic [1:0]       dbg_rc_ptr_o;
  logic [1:0]       dbg_sa_ptr_o;

  int tests_run;
  int tests_failed;

  // model: phase 0 = idle, 1 = waiting for first ack, 2 = packet in flight
  int m_st, m_owner, m_sa_ptr, m_rc_ptr, m_wd;
  bit m_to;

  input_unit_split_arbiter #(.SPLIT(SPLIT), .WDOG_LIMIT(WDOG_LIMIT)) dut (
    .clk            (clk),
    .rst            (rst),
    .rc_req_split   (rc_req_split),
    .rc_ready       (rc_ready),
    .rc_grant_split (rc_grant_split),
    .sa_req_split   (sa_req_split),
    .sa_tail_split  (sa_tail_split),
    .sa_ack         (sa_ack),
    .sa_grant_split (sa_grant_split),
    .sa_locked      (sa_locked),
`ifdef SPLIT_ARB_WDOG_EN
    .sa_timeout     (sa_timeout),
`endif
    .dbg_state_o    (dbg_state_o),
    .dbg_rc_ptr_o   (dbg_rc_ptr_o),
    .dbg_sa_ptr_o   (dbg_sa_ptr_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int rr_pick(input logic [SPLIT-1:0] req, input int ptr);
    for (int i = 0; i < SPLIT; i++) begin
      if (req[(ptr + i) % SPLIT]) return (ptr + i) % SPLIT;
    end
    return -1;
  endfunction

  function automatic logic [SPLIT-1:0] exp_rc();
    int p;
    p = rr_pick(rc_req_split, m_rc_ptr);
    if (!rc_ready || p < 0) return '0;
    return SPLIT'(1 << p);
  endfunction

  function automatic logic [SPLIT-1:0] exp_sa();
    if (m_st == 0 || !sa_req_split[m_owner]) return '0;
    return SPLIT'(1 << m_owner);
  endfunction

  task automatic model_clock();
    int p;
    bit ack_eff;
    if (rst) begin
      m_st = 0; m_owner = 0; m_sa_ptr = 0; m_rc_ptr = 0; m_wd = 0; m_to = 0;
      return;
    end
    m_to = 0;
    p = rr_pick(rc_req_split, m_rc_ptr);
    if (rc_ready && p >= 0) m_rc_ptr = (p + 1) % SPLIT;
    ack_eff = sa_ack && (m_st != 0) && sa_req_split[m_owner];
    if (m_st == 0) begin
      p = rr_pick(sa_req_split, m_sa_ptr);
      if (p >= 0) begin m_st = 1; m_owner = p; m_wd = 0; end
    end else if (m_st == 1) begin
      if (ack_eff) begin
        m_wd = 0;
        if (sa_tail_split[m_owner]) begin m_st = 0; m_sa_ptr = (m_owner + 1) % SPLIT; end
        else m_st = 2;
      end else if (!sa_req_split[m_owner]) begin
        m_st = 0; m_wd = 0;
      end else begin
`ifdef SPLIT_ARB_WDOG_EN
        m_wd++;
        if (m_wd == WDOG_LIMIT) begin
          m_st = 0; m_sa_ptr = (m_owner + 1) % SPLIT; m_to = 1; m_wd = 0;
        end
`endif
      end
    end else begin
      if (ack_eff && sa_tail_split[m_owner]) begin m_st = 0; m_sa_ptr = (m_owner + 1) % SPLIT; end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rc_req_split = '0; rc_ready = 1'b0;
    sa_req_split = '0; sa_tail_split = '0; sa_ack = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    rc_req_split = 4'b0100; rc_ready = 1'b1;
    sa_req_split = 4'b1111; sa_tail_split = 4'b1111; sa_ack = 1'b1;
    step();
    step();
    #1;
    tests_run++; if (sa_grant_split !== 4'b0000) begin tests_failed++; $display("FAIL reset_sa_grant: got %b expected 0000", sa_grant_split); end
    tests_run++; if (sa_locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked: got %b expected 0", sa_locked); end
    tests_run++; if (dbg_state_o !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", dbg_state_o); end
    tests_run++; if (dbg_sa_ptr_o !== 2'd0 || dbg_rc_ptr_o !== 2'd0) begin tests_failed++; $display("FAIL reset_ptrs: got sa=%0d rc=%0d expected 0/0", dbg_sa_ptr_o, dbg_rc_ptr_o); end
    tests_run++; if (rc_grant_split !== 4'b0100) begin tests_failed++; $display("FAIL reset_rc_grant: got %b expected 0100", rc_grant_split); end
`ifdef SPLIT_ARB_WDOG_EN
    tests_run++; if (sa_timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout: got %b expected 0", sa_timeout); end
`endif
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_rc_rotation();
    logic [SPLIT-1:0] tbl [5];
    tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    rc_req_split = 4'b1111; rc_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++; if (rc_grant_split !== tbl[i]) begin tests_failed++; $display("FAIL rc_rotation[%0d]: got %b expected %b", i, rc_grant_split, tbl[i]); end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_rc_gating();
    do_reset();
    rc_req_split = 4'b0100; rc_ready = 1'b0;
    #1;
    tests_run++; if (rc_grant_split !== 4'b0000) begin tests_failed++; $display("FAIL rc_gated: got %b expected 0000", rc_grant_split); end
    step();
    #1;
    tests_run++; if (dbg_rc_ptr_o !== 2'd0) begin tests_failed++; $display("FAIL rc_ptr_hold: got %0d expected 0", dbg_rc_ptr_o); end
    rc_ready = 1'b1;
    #1;
    tests_run++; if (rc_grant_split !== 4'b0100) begin tests_failed++; $display("FAIL rc_ungated: got %b expected 0100", rc_grant_split); end
    step();
    #1;
    tests_run++; if (dbg_rc_ptr_o !== 2'd3) begin tests_failed++; $display("FAIL rc_ptr_adv: got %0d expected 3", dbg_rc_ptr_o); end
    clear_inputs();
  endtask

  task automatic test_single_flit();
    do_reset();
    sa_req_split = 4'b0010; sa_tail_split = 4'b0010;
    #1;
    tests_run++; if (sa_grant_split !== 4'b0000) begin tests_failed++; $display("FAIL sf_idle_grant: got %b expected 0000", sa_grant_split); end
    step();
    #1;
    tests_run++; if (sa_grant_split !== 4'b0010) begin tests_failed++; $display("FAIL sf_grant: got %b expected 0010", sa_grant_split); end
    step();
    sa_ack = 1'b1;
    #1;
    tests_run++; if (sa_grant_split !== 4'b0010 || sa_locked !== 1'b0) begin tests_failed++; $display("FAIL sf_grant_hold: got %b/%b expected 0010/0", sa_grant_split, sa_locked); end
    step();
    clear_inputs();
    #1;
    tests_run++; if (dbg_state_o !== 2'd0 || dbg_sa_ptr_o !== 2'd2) begin tests_failed++; $display("FAIL sf_release: got state=%0d ptr=%0d expected 0/2", dbg_state_o, dbg_sa_ptr_o); end
  endtask

  task automatic test_wormhole();
    logic [2:0] lock_exp;
    lock_exp = 3'b110;
    do_reset();
    sa_req_split = 4'b0011;
    #1;
    tests_run++; if (sa_grant_split !== 4'b0000) begin tests_failed++; $display("FAIL wh_idle: got %b expected 0000", sa_grant_split); end
    step();
    sa_ack = 1'b1;
    for (int f = 0; f < 3; f++) begin
      sa_tail_split = (f == 2) ? 4'b0001 : 4'b0000;
      #1;
      tests_run++; if (sa_grant_split !== 4'b0001) begin tests_failed++; $display("FAIL wh_grant[flit%0d]: got %b expected 0001", f + 1, sa_grant_split); end
      tests_run++; if (sa_locked !== lock_exp[f]) begin tests_failed++; $display("FAIL wh_locked[flit%0d]: got %b expected %b", f + 1, sa_locked, lock_exp[f]); end
      step();
    end
    sa_req_split = 4'b0010; sa_ack = 1'b0; sa_tail_split = '0;
    #1;
    tests_run++; if (sa_grant_split !== 4'b0000 || sa_locked !== 1'b0 || dbg_sa_ptr_o !== 2'd1) begin tests_failed++; $display("FAIL wh_release: got grant=%b lock=%b ptr=%0d expected 0000/0/1", sa_grant_split, sa_locked, dbg_sa_ptr_o); end
    step();
    #1;
    tests_run++; if (sa_grant_split !== 4'b0010) begin tests_failed++; $display("FAIL wh_next_split: got %b expected 0010", sa_grant_split); end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_in_lock();
    do_reset();
    sa_req_split = 4'b0010; sa_tail_split = 4'b0010;
    step();
    sa_ack = 1'b1;
    step();
    sa_req_split = 4'b0100; sa_tail_split = 4'b0000;
    step();
    step();
    #1;
    tests_run++; if (sa_locked !== 1'b1 || dbg_sa_ptr_o !== 2'd2) begin tests_failed++; $display("FAIL ril_pre: got lock=%b ptr=%0d expected 1/2", sa_locked, dbg_sa_ptr_o); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    tests_run++; if (sa_grant_split !== 4'b0000 || sa_locked !== 1'b0 || dbg_sa_ptr_o !== 2'd0) begin tests_failed++; $display("FAIL ril_post: got grant=%b lock=%b ptr=%0d expected 0000/0/0", sa_grant_split, sa_locked, dbg_sa_ptr_o); end
    clear_inputs();
    step();
  endtask

  task automatic test_ack_ignored();
    do_reset();
    sa_ack = 1'b1;
    step();
    step();
    #1;
    tests_run++; if (dbg_state_o !== 2'd0 || dbg_sa_ptr_o !== 2'd0) begin tests_failed++; $display("FAIL ai_idle: got state=%0d ptr=%0d expected 0/0", dbg_state_o, dbg_sa_ptr_o); end
    sa_ack = 1'b0; sa_req_split = 4'b0100;
    step();
    sa_ack = 1'b1;
    step();
    sa_req_split = 4'b0000; sa_tail_split = 4'b0100;
    #1;
    tests_run++; if (sa_grant_split !== 4'b0000) begin tests_failed++; $display("FAIL ai_drop_grant: got %b expected 0000", sa_grant_split); end
    step();
    #1;
    tests_run++; if (dbg_state_o !== 2'd2 || sa_locked !== 1'b1) begin tests_failed++; $display("FAIL ai_hold_lock: got state=%0d lock=%b expected 2/1", dbg_state_o, sa_locked); end
    sa_req_split = 4'b0100;
    #1;
    tests_run++; if (sa_grant_split !== 4'b0100) begin tests_failed++; $display("FAIL ai_regrant: got %b expected 0100", sa_grant_split); end
    step();
    #1;
    tests_run++; if (dbg_state_o !== 2'd0 || dbg_sa_ptr_o !== 2'd3) begin tests_failed++; $display("FAIL ai_release: got state=%0d ptr=%0d expected 0/3", dbg_state_o, dbg_sa_ptr_o); end
    clear_inputs();
  endtask

`ifdef SPLIT_ARB_WDOG_EN
  task automatic test_watchdog();
    do_reset();
    sa_req_split = 4'b0010;
    step();
    for (int k = 0; k < WDOG_LIMIT; k++) begin
      #1;
      tests_run++; if (sa_timeout !== 1'b0 || sa_grant_split !== 4'b0010) begin tests_failed++; $display("FAIL wd_wait[%0d]: got to=%b grant=%b expected 0/0010", k, sa_timeout, sa_grant_split); end
      step();
    end
    #1;
    tests_run++; if (sa_timeout !== 1'b1 || dbg_state_o !== 2'd0 || dbg_sa_ptr_o !== 2'd2) begin tests_failed++; $display("FAIL wd_expire: got to=%b state=%0d ptr=%0d expected 1/0/2", sa_timeout, dbg_state_o, dbg_sa_ptr_o); end
    step();
    #1;
    tests_run++; if (sa_timeout !== 1'b0) begin tests_failed++; $display("FAIL wd_pulse_len: got %b expected 0", sa_timeout); end
    clear_inputs();
  endtask
`else
  task automatic test_req_wait();
    do_reset();
    sa_req_split = 4'b0010;
    step();
    for (int k = 0; k < 20; k++) begin
      #1;
      tests_run++; if (dbg_state_o !== 2'd1 || sa_grant_split !== 4'b0010) begin tests_failed++; $display("FAIL req_wait[%0d]: got state=%0d grant=%b expected 1/0010", k, dbg_state_o, sa_grant_split); end
      step();
    end
    clear_inputs();
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst          = ($urandom_range(0, 99) == 0);
      rc_req_split = SPLIT'($urandom_range(0, 15));
      rc_ready     = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < SPLIT; b++) begin
        if ($urandom_range(0, 4) == 0) sa_req_split[b] = ~sa_req_split[b];
      end
      sa_tail_split = SPLIT'($urandom_range(0, 15));
      sa_ack        = ($urandom_range(0, 1) == 1);
      #1;
      tests_run++; if (rc_grant_split !== exp_rc()) begin tests_failed++; $display("FAIL rnd_rc_grant[%0d]: got %b expected %b", c, rc_grant_split, exp_rc()); end
      tests_run++; if (sa_grant_split !== exp_sa()) begin tests_failed++; $display("FAIL rnd_sa_grant[%0d]: got %b expected %b", c, sa_grant_split, exp_sa()); end
      tests_run++; if (sa_locked !== (m_st == 2)) begin tests_failed++; $display("FAIL rnd_locked[%0d]: got %b expected %b", c, sa_locked, (m_st == 2)); end
      tests_run++; if (dbg_sa_ptr_o !== 2'(m_sa_ptr) || dbg_rc_ptr_o !== 2'(m_rc_ptr)) begin tests_failed++; $display("FAIL rnd_ptrs[%0d]: got sa=%0d rc=%0d expected %0d/%0d", c, dbg_sa_ptr_o, dbg_rc_ptr_o, m_sa_ptr, m_rc_ptr); end
`ifdef SPLIT_ARB_WDOG_EN
      tests_run++; if (sa_timeout !== m_to) begin tests_failed++; $display("FAIL rnd_timeout[%0d]: got %b expected %b", c, sa_timeout, m_to); end
`endif
      step();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tests_run = 0; tests_failed = 0;
    m_st = 0; m_owner = 0; m_sa_ptr = 0; m_rc_ptr = 0; m_wd = 0; m_to = 0;
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_rc_rotation();
    test_rc_gating();
    test_single_flit();
    test_wormhole();
    test_reset_in_lock();
    test_ack_ignored();
`ifdef SPLIT_ARB_WDOG_EN
    test_watchdog();
`else
    test_req_wait();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
